// File: rtl/uspy_cmd_log.sv
// uspy_cmd_log: logs the transaction summaries strobed by the QSPI router
// into a small circular FIFO. The soft CPU drains that FIFO through a
// valid/ready port. When the FIFO is full, new entries are dropped and
// counted, so the SPI path never stalls.
//
// Optional feature: define USPY_CMDLOG_TIMESTAMP_EN to store a free-running
// 32-bit cycle timestamp with each entry. Without it, log_time reads 0.
//
// Head outputs come from registers. In the common case they come from the
// registered RAM read of the slot the read pointer will point at next cycle.
// When that slot is being written in the same cycle, the write data is
// forwarded instead, through a bypass register.
module uspy_cmd_log #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_strobe,
  input  logic [7:0]            cmd_in,
  input  logic [31:0]           addr_in,
  input  logic [11:0]           len_in,
  input  logic                  log_enable,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic [7:0]            log_cmd,
  output logic [31:0]           log_addr,
  output logic [11:0]           log_len,
  output logic [31:0]           log_time,
  output logic [DEPTH_LOG2:0]   log_count,
  output logic [15:0]           drop_count,
  output logic                  overflow,
  input  logic                  stat_clear
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int EW    = 8 + 32 + 12;

  logic [PW-1:0] wp_reg, rp_reg;
  logic [PW-1:0] wp_next, rp_next;
  logic          empty, full;
  logic          push_req, push_acc, pop, drop;
  logic          bypass, next_nonempty, rd_en;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_reg;
  logic [EW-1:0] byp_reg;
  logic          sel_byp_reg;

  logic [15:0]   drop_count_reg;
  logic          overflow_reg;

  // Pointer arithmetic, the push/pop decision and bypass detection
  always_comb begin
    empty         = (wp_reg == rp_reg);
    full          = ((wp_reg ^ rp_reg) == {1'b1, {DEPTH_LOG2{1'b0}}});
    pop           = !empty && log_ready;
    push_req      = cmd_strobe && log_enable;
    push_acc      = push_req && (!full || pop);
    drop          = push_req && full && !pop;
    wp_next       = wp_reg + {{(PW-1){1'b0}}, push_acc};
    rp_next       = rp_reg + {{(PW-1){1'b0}}, pop};
    // The next head is the entry written in this same cycle.
    bypass        = push_acc && (rp_next == wp_reg);
    next_nonempty = (rp_next != wp_next);
    rd_en         = next_nonempty && !bypass;
    wr_entry      = {cmd_in, addr_in, len_in};
  end

  // Read and write pointers; the queue is emptied by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_reg <= '0;
      rp_reg <= '0;
    end else begin
      wp_reg <= wp_next;
      rp_reg <= rp_next;
    end
  end

  // Entry storage: a RAM with synchronous write and an enabled registered read
  always_ff @(posedge clk) begin
    if (push_acc)
      mem[wp_reg[DEPTH_LOG2-1:0]] <= wr_entry;
    if (rd_en)
      rd_reg <= mem[rp_next[DEPTH_LOG2-1:0]];
  end

  // Head source select; the bypass copy also supplies the all-zero reset head
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_byp_reg <= 1'b1;
      byp_reg     <= '0;
    end else if (bypass) begin
      sel_byp_reg <= 1'b1;
      byp_reg     <= wr_entry;
    end else if (rd_en) begin
      sel_byp_reg <= 1'b0;
    end
  end

  // Drop statistics; a clear wins over a drop in the same cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_count_reg <= '0;
      overflow_reg   <= 1'b0;
    end else if (stat_clear) begin
      drop_count_reg <= '0;
      overflow_reg   <= 1'b0;
    end else if (drop) begin
      if (drop_count_reg != 16'hFFFF)
        drop_count_reg <= drop_count_reg + 16'd1;
      overflow_reg <= 1'b1;
    end
  end

  assign log_valid  = !empty;
  assign log_count  = wp_reg - rp_reg;
  assign drop_count = drop_count_reg;
  assign overflow   = overflow_reg;
  assign {log_cmd, log_addr, log_len} = sel_byp_reg ? byp_reg : rd_reg;

`ifdef USPY_CMDLOG_TIMESTAMP_EN
  logic [31:0] ts_reg;
  logic [31:0] ts_mem [DEPTH];
  logic [31:0] ts_rd_reg;
  logic [31:0] ts_byp_reg;

  // Free-running cycle counter that wraps naturally
  always_ff @(posedge clk) begin
    if (!reset)
      ts_reg <= '0;
    else
      ts_reg <= ts_reg + 32'd1;
  end

  // Timestamp storage, kept in step with the entry RAM
  always_ff @(posedge clk) begin
    if (push_acc)
      ts_mem[wp_reg[DEPTH_LOG2-1:0]] <= ts_reg;
    if (rd_en)
      ts_rd_reg <= ts_mem[rp_next[DEPTH_LOG2-1:0]];
  end

  // Timestamp bypass copy, captured alongside the entry bypass
  always_ff @(posedge clk) begin
    if (!reset)
      ts_byp_reg <= '0;
    else if (bypass)
      ts_byp_reg <= ts_reg;
  end

  assign log_time = sel_byp_reg ? ts_byp_reg : ts_rd_reg;
`else
  assign log_time = 32'h0;
`endif

endmodule

// File: tb/tb_uspy_cmd_log.sv
// Self-checking bench for uspy_cmd_log (DEPTH_LOG2 = 4): a table of
// single-cycle vectors, followed by hand-written multi-cycle sequences.
module tb_uspy_cmd_log;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_strobe;
  logic [7:0]  cmd_in;
  logic [31:0] addr_in;
  logic [11:0] len_in;
  logic        log_enable;
  logic        log_valid;
  logic        log_ready;
  logic [7:0]  log_cmd;
  logic [31:0] log_addr;
  logic [11:0] log_len;
  logic [31:0] log_time;
  logic [4:0]  log_count;
  logic [15:0] drop_count;
  logic        overflow;
  logic        stat_clear;

  int pass_cnt = 0;
  int total_cnt = 0;

  uspy_cmd_log #(.DEPTH_LOG2(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_strobe (cmd_strobe),
    .cmd_in     (cmd_in),
    .addr_in    (addr_in),
    .len_in     (len_in),
    .log_enable (log_enable),
    .log_valid  (log_valid),
    .log_ready  (log_ready),
    .log_cmd    (log_cmd),
    .log_addr   (log_addr),
    .log_len    (log_len),
    .log_time   (log_time),
    .log_count  (log_count),
    .drop_count (drop_count),
    .overflow   (overflow),
    .stat_clear (stat_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        strobe;
    logic        en;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [11:0] len;
    logic        ready;
    logic        clr;
    logic        e_valid;
    logic [7:0]  e_cmd;
    logic [31:0] e_addr;
    logic [11:0] e_len;
    logic [4:0]  e_count;
    logic [15:0] e_drop;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // One clock edge; outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmd_strobe = 1'b0;
    cmd_in     = 8'h00;
    addr_in    = 32'h0;
    len_in     = 12'h0;
    log_ready  = 1'b0;
    stat_clear = 1'b0;
    log_enable = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic push1(input logic [7:0] c, input logic [31:0] a, input logic [11:0] l);
    cmd_strobe = 1'b1;
    cmd_in     = c;
    addr_in    = a;
    len_in     = l;
    step();
    cmd_strobe = 1'b0;
  endtask

  logic [31:0] t1, t2;

  initial begin
    reset = 1'b1;
    idle();
    do_reset();

    // Reset state
    check("rst_valid", {31'd0, log_valid}, 32'd0);
    check("rst_count", {27'd0, log_count}, 32'd0);
    check("rst_drop",  {16'd0, drop_count}, 32'd0);
    check("rst_ovf",   {31'd0, overflow}, 32'd0);
    check("rst_cmd",   {24'd0, log_cmd}, 32'd0);
    check("rst_addr",  log_addr, 32'd0);
    check("rst_len",   {20'd0, log_len}, 32'd0);
    check("rst_time",  log_time, 32'd0);

    // Vector table:      stb en  cmd     addr           len      rdy clr  | valid cmd    addr           len      cnt   drop    ovf
    vecs[0] = '{1'b1, 1'b1, 8'h03, 32'h00123456, 12'h104, 1'b0, 1'b0, 1'b1, 8'h03, 32'h00123456, 12'h104, 5'd1, 16'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'hFF, 32'hFFFFFFFF, 12'hFFF, 1'b0, 1'b0, 1'b1, 8'h03, 32'h00123456, 12'h104, 5'd1, 16'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 32'h00000000, 12'h000, 1'b1, 1'b0, 1'b0, 8'h00, 32'h00000000, 12'h000, 5'd0, 16'd0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'hA5, 32'hDEADBEEF, 12'h005, 1'b1, 1'b0, 1'b1, 8'hA5, 32'hDEADBEEF, 12'h005, 5'd1, 16'd0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'h0B, 32'h00000001, 12'h002, 1'b1, 1'b0, 1'b1, 8'h0B, 32'h00000001, 12'h002, 5'd1, 16'd0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h77, 32'h77777777, 12'h777, 1'b0, 1'b0, 1'b1, 8'h0B, 32'h00000001, 12'h002, 5'd1, 16'd0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 32'h00000000, 12'h000, 1'b1, 1'b0, 1'b0, 8'h00, 32'h00000000, 12'h000, 5'd0, 16'd0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 32'h00000000, 12'h000, 1'b0, 1'b1, 1'b0, 8'h00, 32'h00000000, 12'h000, 5'd0, 16'd0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      cmd_strobe = vecs[i].strobe;
      log_enable = vecs[i].en;
      cmd_in     = vecs[i].cmd;
      addr_in    = vecs[i].addr;
      len_in     = vecs[i].len;
      log_ready  = vecs[i].ready;
      stat_clear = vecs[i].clr;
      step();
      $display("vec %0d: valid=%0b cmd=%h addr=%h len=%h count=%0d drop=%0d ovf=%0b",
               i, log_valid, log_cmd, log_addr, log_len, log_count, drop_count, overflow);
      check($sformatf("vec%0d_valid", i), {31'd0, log_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("vec%0d_count", i), {27'd0, log_count}, {27'd0, vecs[i].e_count});
      check($sformatf("vec%0d_drop", i), {16'd0, drop_count}, {16'd0, vecs[i].e_drop});
      check($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].e_ovf});
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_cmd", i), {24'd0, log_cmd}, {24'd0, vecs[i].e_cmd});
        check($sformatf("vec%0d_addr", i), log_addr, vecs[i].e_addr);
        check($sformatf("vec%0d_len", i), {20'd0, log_len}, {20'd0, vecs[i].e_len});
      end
    end
    idle();

    // 18 back-to-back pushes into a 16-deep FIFO: two drops
    for (int i = 1; i <= 18; i++)
      push1(8'(i), 32'h1000 + 32'(i), 12'(i));
    $display("fill18: count=%0d drop=%0d ovf=%0b", log_count, drop_count, overflow);
    check("fill18_count", {27'd0, log_count}, 32'd16);
    check("fill18_drop", {16'd0, drop_count}, 32'd2);
    check("fill18_ovf", {31'd0, overflow}, 32'd1);
    check("fill18_valid", {31'd0, log_valid}, 32'd1);
    log_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      $display("drain %0d: cmd=%h addr=%h", i, log_cmd, log_addr);
      check($sformatf("drain%0d_cmd", i), {24'd0, log_cmd}, 32'(i));
      check($sformatf("drain%0d_addr", i), log_addr, 32'h1000 + 32'(i));
      step();
    end
    log_ready = 1'b0;
    check("drain_end_valid", {31'd0, log_valid}, 32'd0);
    check("drain_end_count", {27'd0, log_count}, 32'd0);

    // Full FIFO with a simultaneous push and pop
    for (int i = 1; i <= 16; i++)
      push1(8'(i), 32'h2000 + 32'(i), 12'(i));
    check("refill_count", {27'd0, log_count}, 32'd16);
    log_ready = 1'b1;
    push1(8'hEE, 32'hCAFE0000, 12'h0FF);
    log_ready = 1'b0;
    $display("pushpop full: count=%0d drop=%0d", log_count, drop_count);
    check("pushpop_count", {27'd0, log_count}, 32'd16);
    check("pushpop_drop", {16'd0, drop_count}, 32'd2);
    log_ready = 1'b1;
    for (int i = 2; i <= 16; i++) begin
      check($sformatf("pp_drain%0d_cmd", i), {24'd0, log_cmd}, 32'(i));
      step();
    end
    $display("pushpop last: cmd=%h addr=%h len=%h", log_cmd, log_addr, log_len);
    check("pp_last_cmd", {24'd0, log_cmd}, 32'hEE);
    check("pp_last_addr", log_addr, 32'hCAFE0000);
    check("pp_last_len", {20'd0, log_len}, 32'h0FF);
    step();
    log_ready = 1'b0;
    check("pp_end_valid", {31'd0, log_valid}, 32'd0);

    // Clear the statistics, then log_enable low ignores strobes
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    check("clr_drop", {16'd0, drop_count}, 32'd0);
    check("clr_ovf", {31'd0, overflow}, 32'd0);
    log_enable = 1'b0;
    for (int i = 0; i < 5; i++)
      push1(8'h40 + 8'(i), 32'h3000, 12'h1);
    log_enable = 1'b1;
    $display("disabled pushes: count=%0d drop=%0d", log_count, drop_count);
    check("dis_count", {27'd0, log_count}, 32'd0);
    check("dis_drop", {16'd0, drop_count}, 32'd0);
    check("dis_valid", {31'd0, log_valid}, 32'd0);

    // Drop on a full FIFO, then a clear that coincides with a drop
    for (int i = 1; i <= 16; i++)
      push1(8'(i), 32'h4000, 12'h1);
    push1(8'h99, 32'h4099, 12'h1);
    check("drop1_drop", {16'd0, drop_count}, 32'd1);
    check("drop1_ovf", {31'd0, overflow}, 32'd1);
    stat_clear = 1'b1;
    push1(8'h9A, 32'h409A, 12'h1);
    stat_clear = 1'b0;
    $display("clear+drop: count=%0d drop=%0d ovf=%0b", log_count, drop_count, overflow);
    check("clrdrop_drop", {16'd0, drop_count}, 32'd0);
    check("clrdrop_ovf", {31'd0, overflow}, 32'd0);
    check("clrdrop_count", {27'd0, log_count}, 32'd16);

    // A one-cycle reset pulse discards queued entries and statistics
    do_reset();
    for (int i = 1; i <= 16; i++)
      push1(8'(i), 32'h5000, 12'h1);
    push1(8'h55, 32'h5055, 12'h1);
    idle();
    do_reset();
    for (int i = 1; i <= 3; i++)
      push1(8'(i), 32'h6000 + 32'(i), 12'h1);
    check("pre_rst_count", {27'd0, log_count}, 32'd3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    $display("reset pulse: valid=%0b count=%0d drop=%0d", log_valid, log_count, drop_count);
    check("rstp_valid", {31'd0, log_valid}, 32'd0);
    check("rstp_count", {27'd0, log_count}, 32'd0);
    check("rstp_drop", {16'd0, drop_count}, 32'd0);
    check("rstp_cmd", {24'd0, log_cmd}, 32'd0);

    // Two pushes 15 cycles apart
    push1(8'h51, 32'h7000, 12'h1);
    for (int i = 0; i < 14; i++)
      step();
    push1(8'h52, 32'h7001, 12'h1);
    check("ts_count", {27'd0, log_count}, 32'd2);
    check("ts_cmd1", {24'd0, log_cmd}, 32'h51);
    t1 = log_time;
    log_ready = 1'b1;
    step();
    log_ready = 1'b0;
    check("ts_cmd2", {24'd0, log_cmd}, 32'h52);
    t2 = log_time;
    $display("timestamps: t1=%0d t2=%0d", t1, t2);
`ifdef USPY_CMDLOG_TIMESTAMP_EN
    check("ts_delta", t2 - t1, 32'd15);
`else
    check("ts_zero1", t1, 32'd0);
    check("ts_zero2", t2, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
